// File: rtl/free_list_pkg.sv
// Shared core definitions for the physical-register free list: sizes, depth and tag type.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package free_list_pkg;
  localparam int N_WAY    = `N_WAY;
  localparam int N_PRF    = 64;
  localparam int N_ARF    = 32;
  localparam int CDB_BITS = `CDB_BITS;
  localparam int FL_DEPTH = N_PRF - N_ARF;

  typedef logic [CDB_BITS-1:0] FL_TAG;
endpackage

// File: rtl/free_list_slot_compact.sv
// Exclusive prefix rank of each set bit in a slot-valid vector, plus the total set count.
module slot_compact #(
  parameter int N  = 2,
  parameter int RW = $clog2(N) + 1
) (
  input  logic [N-1:0]         valid,
  output logic [N-1:0][RW-1:0] rank,
  output logic [RW-1:0]        total
);
  logic [RW-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int k = 0; k < N; k++) begin
      rank[k] = acc;
      if (valid[k]) acc = acc + RW'(1);
    end
    total = acc;
  end
endmodule

// File: rtl/free_list.sv
// R10K-style physical-register free list: circular FIFO of free tags, N_WAY pops and pushes per cycle.
// Optional retire-time flush recovery (arch_head + flush port) is enabled by FREE_LIST_RECOVER_EN.
`ifndef N_WAY
`define N_WAY 2
`endif

module free_list
  import free_list_pkg::*;
#(
  parameter int N_WAY    = `N_WAY,
  parameter int N_PRF    = 64,
  parameter int N_ARF    = 32,
  parameter int CDB_BITS = $clog2(N_PRF)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_WAY-1:0]                 alloc_req,
  output logic [N_WAY-1:0]                 alloc_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]   alloc_tag,
  input  logic [N_WAY-1:0]                 retire_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]   retire_tag,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]   retire_told,
  output logic [$clog2(N_WAY):0]           avail,
  output logic [$clog2(N_PRF):0]           free_count
`ifdef FREE_LIST_RECOVER_EN
  ,
  input  logic                             flush
`endif
);
  localparam int DEPTH = N_PRF - N_ARF;
  localparam int PW    = $clog2(DEPTH);
  localparam int RW    = $clog2(N_WAY) + 1;
  localparam int CW    = $clog2(N_PRF) + 1;

  logic [CDB_BITS-1:0]        buffer [DEPTH];
  logic [PW-1:0]              head, tail, head_next;
  logic [CW-1:0]              count, count_next;
  logic [CW:0]                count_sum;
  logic [N_WAY-1:0]           push_valid;
  logic [N_WAY-1:0][RW-1:0]   rank_alloc, rank_push;
  logic [RW-1:0]              req_total, push_total, grants;
  logic                       flush_i;

  // Pointer advance modulo DEPTH; offsets never exceed N_WAY so one subtraction suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [RW-1:0] off);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < N_WAY; k++)
      push_valid[k] = retire_valid[k] && (retire_tag[k] != '0);
  end

  slot_compact #(.N(N_WAY), .RW(RW)) u_alloc_rank (
    .valid (alloc_req),
    .rank  (rank_alloc),
    .total (req_total)
  );

  slot_compact #(.N(N_WAY), .RW(RW)) u_push_rank (
    .valid (push_valid),
    .rank  (rank_push),
    .total (push_total)
  );

`ifdef FREE_LIST_RECOVER_EN
  logic [PW-1:0] arch_head, arch_head_next;
  assign flush_i        = flush;
  assign arch_head_next = ptr_add(arch_head, push_total);
`else
  assign flush_i = 1'b0;
`endif

  always_comb begin
    grants      = '0;
    alloc_valid = '0;
    alloc_tag   = '0;
    for (int k = 0; k < N_WAY; k++) begin
      if (alloc_req[k] && (CW'(rank_alloc[k]) < count) && !flush_i) begin
        alloc_valid[k] = 1'b1;
        alloc_tag[k]   = buffer[ptr_add(head, rank_alloc[k])];
        grants         = grants + RW'(1);
      end
    end
  end

  assign count_sum  = {1'b0, count} + (CW+1)'(push_total) - (CW+1)'(grants);
  assign avail      = (count >= CW'(N_WAY)) ? RW'(N_WAY) : count[RW-1:0];
  assign free_count = count;

  always_comb begin
    head_next  = ptr_add(head, grants);
    count_next = count_sum[CW-1:0];
`ifdef FREE_LIST_RECOVER_EN
    // The architectural free count is invariant, so a flush restores a full list at arch_head.
    if (flush_i) begin
      head_next  = arch_head_next;
      count_next = CW'(DEPTH);
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++)
        buffer[i] <= CDB_BITS'(N_ARF + i);
`ifdef FREE_LIST_RECOVER_EN
      arch_head <= '0;
`endif
    end else begin
      for (int k = 0; k < N_WAY; k++)
        if (push_valid[k])
          buffer[ptr_add(tail, rank_push[k])] <= retire_told[k];
      tail  <= ptr_add(tail, push_total);
      head  <= head_next;
      count <= count_next;
`ifdef FREE_LIST_RECOVER_EN
      arch_head <= arch_head_next;
`endif
    end
  end

  for (genvar k = 0; k < N_WAY; k++) begin : g_told_chk
    a_told_nonzero: assert property (@(posedge clock) disable iff (reset)
      !(retire_valid[k] && (retire_tag[k] != '0) && (retire_told[k] == '0)));
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    flush_i || (count_sum <= (CW+1)'(DEPTH)));
endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list (default 2-wide, 64 phys / 32 arch registers).
`timescale 1ns/1ps
module tb_free_list;
  localparam int N  = 2;
  localparam int CB = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [N-1:0]       alloc_req = '0;
  logic [N-1:0]       alloc_valid;
  logic [N-1:0][CB-1:0] alloc_tag;
  logic [N-1:0]       retire_valid = '0;
  logic [N-1:0][CB-1:0] retire_tag = '0;
  logic [N-1:0][CB-1:0] retire_told = '0;
  logic [1:0]         avail;
  logic [6:0]         free_count;
`ifdef FREE_LIST_RECOVER_EN
  logic               flush = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .retire_told  (retire_told),
    .avail        (avail),
    .free_count   (free_count)
`ifdef FREE_LIST_RECOVER_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic retire_idle();
    retire_valid = '0;
    retire_tag   = '0;
    retire_told  = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    alloc_req = '0;
    retire_idle();
    do_reset();
    checks++; if (free_count !== 7'd32) $display("FAIL reset_free_count got %0d want 32", free_count); else passes++;
    checks++; if (avail !== 2'd2) $display("FAIL reset_avail got %0d want 2", avail); else passes++;
    checks++; if (alloc_valid !== 2'b00 || alloc_tag !== '0)
      $display("FAIL reset_idle_grant got v=%b tags=%h want v=00 tags=0", alloc_valid, alloc_tag); else passes++;
  endtask

  task automatic test_alloc();
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_valid !== 2'b11 || alloc_tag[0] !== 6'd32 || alloc_tag[1] !== 6'd33)
      $display("FAIL alloc_first got v=%b t0=%0d t1=%0d want 11 32 33", alloc_valid, alloc_tag[0], alloc_tag[1]); else passes++;
    step();
    checks++; if (free_count !== 7'd30) $display("FAIL alloc_count1 got %0d want 30", free_count); else passes++;
    checks++; if (alloc_tag[0] !== 6'd34 || alloc_tag[1] !== 6'd35)
      $display("FAIL alloc_second got t0=%0d t1=%0d want 34 35", alloc_tag[0], alloc_tag[1]); else passes++;
    step();
    checks++; if (free_count !== 7'd28) $display("FAIL alloc_count2 got %0d want 28", free_count); else passes++;
  endtask

  task automatic test_drain();
    alloc_req = 2'b11;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (alloc_valid !== 2'b11 || alloc_tag[0] !== CB'(36 + 2*i) || alloc_tag[1] !== CB'(37 + 2*i))
        $display("FAIL drain_tags[%0d] got v=%b t0=%0d t1=%0d want 11 %0d %0d",
                 i, alloc_valid, alloc_tag[0], alloc_tag[1], 36 + 2*i, 37 + 2*i);
      else passes++;
      step();
    end
    checks++; if (free_count !== 7'd0) $display("FAIL drain_count got %0d want 0", free_count); else passes++;
    checks++; if (avail !== 2'd0) $display("FAIL drain_avail got %0d want 0", avail); else passes++;
    checks++; if (alloc_valid !== 2'b00 || alloc_tag !== '0)
      $display("FAIL drain_empty_grant got v=%b tags=%h want 00 0", alloc_valid, alloc_tag); else passes++;
    step();
    checks++; if (free_count !== 7'd0) $display("FAIL drain_hold got %0d want 0", free_count); else passes++;
  endtask

  task automatic test_partial();
    alloc_req      = 2'b00;
    retire_valid   = 2'b01;
    retire_tag[0]  = 6'd40;
    retire_told[0] = 6'd9;
    step();
    retire_idle();
    checks++; if (free_count !== 7'd1 || avail !== 2'd1)
      $display("FAIL partial_count got fc=%0d av=%0d want 1 1", free_count, avail); else passes++;
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_valid !== 2'b01 || alloc_tag[0] !== 6'd9 || alloc_tag[1] !== 6'd0)
      $display("FAIL partial_11 got v=%b t0=%0d t1=%0d want 01 9 0", alloc_valid, alloc_tag[0], alloc_tag[1]); else passes++;
    alloc_req = 2'b10;
    #1;
    checks++; if (alloc_valid !== 2'b10 || alloc_tag[1] !== 6'd9 || alloc_tag[0] !== 6'd0)
      $display("FAIL partial_10 got v=%b t0=%0d t1=%0d want 10 0 9", alloc_valid, alloc_tag[0], alloc_tag[1]); else passes++;
    step();
    alloc_req = 2'b00;
    checks++; if (free_count !== 7'd0) $display("FAIL partial_pop got %0d want 0", free_count); else passes++;
  endtask

  task automatic test_push_pop_empty();
    alloc_req    = 2'b11;
    retire_valid = 2'b11;
    retire_tag   = {6'd41, 6'd40};
    retire_told  = {6'd7, 6'd5};
    #1;
    checks++; if (alloc_valid !== 2'b00 || avail !== 2'd0)
      $display("FAIL empty_bypass got v=%b av=%0d want 00 0", alloc_valid, avail); else passes++;
    step();
    retire_idle();
    checks++; if (alloc_valid !== 2'b11 || alloc_tag[0] !== 6'd5 || alloc_tag[1] !== 6'd7)
      $display("FAIL empty_refill got v=%b t0=%0d t1=%0d want 11 5 7", alloc_valid, alloc_tag[0], alloc_tag[1]); else passes++;
    checks++; if (free_count !== 7'd2) $display("FAIL empty_refill_count got %0d want 2", free_count); else passes++;
    step();
    alloc_req = 2'b00;
    checks++; if (free_count !== 7'd0) $display("FAIL empty_redrain got %0d want 0", free_count); else passes++;
  endtask

  task automatic test_wrap();
    int q[$];
    int e0, e1, t0, t1;
    alloc_req    = 2'b00;
    retire_valid = 2'b11;
    retire_tag   = {6'd50, 6'd51};
    retire_told  = {6'd11, 6'd10};
    step();
    retire_told  = {6'd13, 6'd12};
    step();
    q = '{10, 11, 12, 13};
    alloc_req = 2'b11;
    for (int i = 0; i < 40; i++) begin
      t0 = 1 + (2*i) % 60;
      t1 = t0 + 1;
      retire_told = {CB'(t1), CB'(t0)};
      #1;
      e0 = q.pop_front();
      e1 = q.pop_front();
      checks++;
      if (alloc_valid !== 2'b11 || alloc_tag[0] !== CB'(e0) || alloc_tag[1] !== CB'(e1))
        $display("FAIL wrap_tags[%0d] got v=%b t0=%0d t1=%0d want 11 %0d %0d",
                 i, alloc_valid, alloc_tag[0], alloc_tag[1], e0, e1);
      else passes++;
      checks++;
      if (free_count !== 7'd4) $display("FAIL wrap_count[%0d] got %0d want 4", i, free_count); else passes++;
      q.push_back(t0);
      q.push_back(t1);
      step();
    end
    alloc_req = 2'b00;
    retire_idle();
  endtask

  task automatic test_async_reset();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (free_count !== 7'd32 || avail !== 2'd2)
      $display("FAIL async_reset got fc=%0d av=%0d want 32 2", free_count, avail); else passes++;
    reset = 1'b0;
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_valid !== 2'b01 || alloc_tag[0] !== 6'd32)
      $display("FAIL async_reset_head got v=%b t0=%0d want 01 32", alloc_valid, alloc_tag[0]); else passes++;
    alloc_req = 2'b00;
  endtask

`ifdef FREE_LIST_RECOVER_EN
  task automatic test_recover();
    alloc_req = 2'b00;
    retire_idle();
    do_reset();
    alloc_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alloc_tag[0] !== CB'(32 + 2*i) || alloc_tag[1] !== CB'(33 + 2*i))
        $display("FAIL recover_alloc[%0d] got t0=%0d t1=%0d want %0d %0d",
                 i, alloc_tag[0], alloc_tag[1], 32 + 2*i, 33 + 2*i);
      else passes++;
      step();
    end
    flush        = 1'b1;
    retire_valid = 2'b11;
    retire_tag   = {6'd33, 6'd32};
    retire_told  = {6'd4, 6'd3};
    #1;
    checks++; if (alloc_valid !== 2'b00) $display("FAIL recover_flush_grant got %b want 00", alloc_valid); else passes++;
    step();
    flush = 1'b0;
    retire_idle();
    alloc_req = 2'b01;
    #1;
    checks++; if (free_count !== 7'd32) $display("FAIL recover_count got %0d want 32", free_count); else passes++;
    checks++; if (alloc_tag[0] !== 6'd34) $display("FAIL recover_head got %0d want 34", alloc_tag[0]); else passes++;
    alloc_req = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_drain();
    test_partial();
    test_push_pop_empty();
    test_wrap();
    test_async_reset();
`ifdef FREE_LIST_RECOVER_EN
    test_recover();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
